// File: rtl/fifo_reader_pkg.sv
// Shared types and default widths for the FIFO read-side controller.
package fifo_reader_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_reader_skid_buf2.sv
// Two-entry register buffer that absorbs the FIFO's one-cycle read latency.
module skid_buf2
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [1:0]        occ_o,
  output logic [DATA_W-1:0] head_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic              do_pop;

  assign do_pop  = pop_i && (occ_q != 2'd0);
  assign occ_o   = occ_q;
  assign head_o  = head_q;
  assign valid_o = (occ_q != 2'd0);

  // Next entry contents; simultaneous push and pop shifts the tail forward
  // and appends the new word behind it so ordering is preserved.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({push_i, do_pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_data_i;
        else               tail_d = push_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller: bursts FIFO words out on threshold, idle timeout or flush.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned BURST_THRESH = 16,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] buf_out,
  input  logic              buf_empty,
  input  logic [CNT_W-1:0]  fifo_counter,
  output logic              rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              flush,
  output logic              busy,
  output logic [15:0]       rd_count
);

  localparam int unsigned      BC_W   = $clog2(BURST_LEN + 1);
  localparam logic [BC_W-1:0]  BLEN   = BC_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(BURST_THRESH);
  localparam logic [7:0]       TMO    = 8'(TIMEOUT);
  localparam bit               TMO_EN = (TIMEOUT != 0);

  state_e          state_q, state_d;
  logic [BC_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [7:0]      timer_q, timer_d;
  logic            inflight_q;
  logic            busy_q, busy_d;
  logic [15:0]     rd_count_q, rd_count_d;

  logic [1:0]      occ;
  logic [2:0]      pending;
  logic            pop;
  logic            credit_ok;
  logic            burst_room;
  logic            thresh_hit;
  logic            timeout_hit;

  skid_buf2 #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (inflight_q),
    .push_data_i (buf_out),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_o      (m_data),
    .valid_o     (m_valid)
  );

  assign pop = m_valid && m_ready;

  // Credit counts the buffered word plus the one in flight; a same-cycle pop
  // frees a slot, which is why m_ready feeds rd_en combinationally.
  assign pending    = {1'b0, occ} + {2'b00, inflight_q};
  assign credit_ok  = pending < (3'd2 + {2'b00, pop});
  assign burst_room = (state_q == ST_DRAIN) || (burst_cnt_q < BLEN);
  assign rd_en      = (state_q != ST_IDLE) && !buf_empty && credit_ok && burst_room;

  assign thresh_hit  = fifo_counter >= THRESH;
  assign timeout_hit = TMO_EN && !buf_empty && (timer_q == TMO);

  assign busy     = busy_q;
  assign rd_count = rd_count_q;

  // Next state and burst length tracking; flush wins over other triggers.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        burst_cnt_d = '0;
        if (flush)                          state_d = ST_DRAIN;
        else if (thresh_hit || timeout_hit) state_d = ST_READ;
      end
      ST_READ: begin
        if (rd_en) burst_cnt_d = burst_cnt_q + BC_W'(1);
        if (flush)                                 state_d = ST_DRAIN;
        else if ((burst_cnt_d == BLEN) || buf_empty) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (buf_empty && !inflight_q && !flush) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Idle timer, busy and delivered-word counter next values.
  always_comb begin
    timer_d = '0;
    if (TMO_EN && (state_q == ST_IDLE) && (state_d == ST_IDLE) && !buf_empty)
      timer_d = (timer_q == TMO) ? timer_q : timer_q + 8'd1;
    busy_d     = (state_q != ST_IDLE) || (occ != 2'd0);
    rd_count_d = rd_count_q + {15'd0, pop};
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
      timer_q     <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      timer_q     <= timer_d;
      inflight_q  <= rd_en;
      busy_q      <= busy_d;
      rd_count_q  <= rd_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural FIFO and an output scoreboard.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  buf_out = '0;
  logic        buf_empty;
  logic [6:0]  fifo_counter;
  logic        rd_en;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        flush;
  logic        busy;
  logic [15:0] rd_count;

  fifo_reader #(
    .DATA_W      (8),
    .CNT_W       (7),
    .BURST_THRESH(16),
    .BURST_LEN   (16),
    .TIMEOUT     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .buf_out     (buf_out),
    .buf_empty   (buf_empty),
    .fifo_counter(fifo_counter),
    .rd_en       (rd_en),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .flush       (flush),
    .busy        (busy),
    .rd_count    (rd_count)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: one-cycle read latency, bulk load in a single edge.
  logic [7:0] fq[$];
  logic [7:0] stage[$];
  logic       load_req = 1'b0;
  int         fifo_cnt = 0;

  always @(posedge clk) begin
    if (rd_en && fq.size() > 0) buf_out <= fq.pop_front();
    if (load_req) while (stage.size() > 0) fq.push_back(stage.pop_front());
    fifo_cnt <= fq.size();
  end

  assign buf_empty    = (fifo_cnt == 0);
  assign fifo_counter = 7'(fifo_cnt);

  int         n_pass = 0;
  int         n_chk  = 0;
  logic [7:0] exp_q[$];
  int         outst = 0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  int         cyc = 0;
  bit         bp_mode = 1'b0;
  logic       rdy_level = 1'b1;
  bit [3:0]   pat = 4'b1001;
  int         ph_reads = 0;
  int         ph_pops = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      stage.push_back(8'(base + i));
      exp_q.push_back(8'(base + i));
    end
    load_req = 1'b1;
  endtask

  // One clock: drive m_ready for the coming edge, then monitor the cycle.
  task automatic tick();
    int pop_i;
    int acc_i;
    @(negedge clk);
    load_req = 1'b0;
    cyc++;
    m_ready = bp_mode ? pat[cyc[1:0]] : rdy_level;
    #1;
    pop_i = (m_valid && m_ready) ? 1 : 0;
    acc_i = (rd_en && !buf_empty) ? 1 : 0;
    if (rd_en) begin
      check("rd_nonempty", 32'(buf_empty), 32'd0);
      check("rd_credit", 32'((outst - pop_i) < 2), 32'd1);
      ph_reads++;
    end
    if (prev_hold) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(prev_data));
    end
    if (pop_i == 1) begin
      check("sb_has_word", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("data", 32'(m_data), 32'(exp_q.pop_front()));
      ph_pops++;
    end
    outst     = outst + acc_i - pop_i;
    prev_hold = m_valid && !m_ready;
    prev_data = m_data;
  endtask

  task automatic wait_drain(input string tag, input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      tick();
      done = (exp_q.size() == 0) && (fifo_cnt == 0) && (outst == 0) && !busy && !m_valid;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int first_valid;
    int lost;
    int exp_rc;

    rst = 1'b0;
    flush = 1'b1;
    m_ready = 1'b1;
    rdy_level = 1'b1;

    // Reset held with flush and ready asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rd_en", 32'(rd_en), 32'd0);
    end
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    flush = 1'b0;
    tick();
    rst = 1'b1;

    // Below threshold: no read right after reset release.
    ph_reads = 0; ph_pops = 0;
    load(10, 'h30);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("below_thresh_no_rd", 32'(rd_en), 32'd0);
    end
    wait_drain("below_thresh_drain", 100);
    check("below_thresh_rdcount", 32'(rd_count), 32'd10);

    // Threshold burst of 16 out of 20.
    ph_reads = 0; ph_pops = 0;
    first_valid = -1;
    load(20, 1);
    for (int kk = 0; kk <= 22; kk++) begin
      tick();
      if (first_valid < 0 && m_valid) first_valid = kk;
      if (kk == 18) check("thr_pops_consecutive", 32'(ph_pops), 32'd16);
    end
    check("thr_first_valid", 32'(first_valid), 32'd3);
    check("thr_reads", 32'(ph_reads), 32'd16);
    check("thr_left_in_fifo", 32'(fifo_cnt), 32'd4);
    check("thr_busy", 32'(busy), 32'd0);
    check("thr_rdcount", 32'(rd_count), 32'd26);
    wait_drain("thr_tail_drain", 100);
    check("thr_tail_rdcount", 32'(rd_count), 32'd30);

    // Idle timeout with 3 words.
    load(3, 'hA0);
    k = 0;
    tick();
    while (!rd_en && k < 20) begin
      tick();
      k++;
    end
    check("tmo_latency", 32'(k), 32'd9);
    wait_drain("tmo_drain", 100);
    check("tmo_rdcount", 32'(rd_count), 32'd33);

    // Backpressure with ready pattern 1,0,0,1.
    ph_reads = 0; ph_pops = 0;
    bp_mode = 1'b1;
    load(16, 'h60);
    wait_drain("bp_drain", 300);
    bp_mode = 1'b0;
    check("bp_pops", 32'(ph_pops), 32'd16);
    check("bp_reads", 32'(ph_reads), 32'd16);
    check("bp_rdcount", 32'(rd_count), 32'd49);

    // Flush pulse with 40 words stored.
    ph_reads = 0; ph_pops = 0;
    load(40, 'h80);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_drain("flush_drain", 300);
    check("flush_pops", 32'(ph_pops), 32'd40);
    check("flush_reads", 32'(ph_reads), 32'd40);
    check("flush_rdcount", 32'(rd_count), 32'd89);
    check("flush_busy", 32'(busy), 32'd0);

    // Reset five words into a burst.
    ph_reads = 0; ph_pops = 0;
    load(20, 'h10);
    k = 0;
    while (ph_pops < 5 && k < 40) begin
      tick();
      k++;
    end
    check("mid_pops_reached", 32'(ph_pops), 32'd5);
    rst = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_rd_en", 32'(rd_en), 32'd0);
    check("mid_rst_rd_count", 32'(rd_count), 32'd0);
    check("mid_rst_m_data", 32'(m_data), 32'd0);
    lost = exp_q.size() - fifo_cnt;
    for (int i = 0; i < lost; i++) void'(exp_q.pop_front());
    exp_rc    = fifo_cnt;
    outst     = 0;
    prev_hold = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_no_rd", 32'(rd_en), 32'd0);
    end
    wait_drain("post_rst_drain", 200);
    check("post_rst_rdcount", 32'(rd_count), 32'(exp_rc));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the 8-bit, 64-deep synchronous FIFO. It sits between the FIFO's read port (`rd_en`, `buf_out`, `buf_empty`, `fifo_counter`) and a downstream valid/ready stream. It gathers data into bursts, either on a fill threshold, on an idle timeout or on an explicit flush. It absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, so throughput is one word per cycle with no dropped or duplicated words under backpressure.

## Interface
- `DATA_W`, 8, FIFO data width
- `CNT_W`, 7, width of the FIFO occupancy count (0..64)
- `BURST_THRESH`, 16, occupancy at or above which a burst starts
- `BURST_LEN`, 16, maximum reads issued per burst
- `TIMEOUT`, 255, idle cycles with a non-empty FIFO before a partial burst is forced; 0 disables the timeout
- `clk  in  1`  rising-edge clock
- `rst  in  1`  asynchronous, active-low reset
- `buf_out  in  DATA_W`  FIFO read data, valid the cycle after an accepted read
- `buf_empty  in  1`  FIFO empty flag
- `fifo_counter  in  CNT_W`  FIFO occupancy
- `rd_en  out  1`  FIFO read strobe
- `m_data  out  DATA_W`  stream data
- `m_valid  out  1`  stream valid
- `m_ready  in  1`  stream ready
- `flush  in  1`  level request to drain the FIFO completely
- `busy  out  1`  high in any state other than IDLE, or while the buffer is non-empty
- `rd_count  out  16`  count of words delivered downstream; wraps modulo 2^16

## Operation
- **Accepted read:** a cycle with `rd_en=1` and `buf_empty=0`. `rd_en` is only ever driven when `buf_empty=0`.
- **In-flight flag:** set on an accepted read; the word is written into the buffer on the following cycle.
- **Buffer:** 2-entry FIFO of registers, occupancy `occ` in 0..2.
  - `m_valid` is `occ != 0`; `m_data` is the head entry.
  - A pop happens on `m_valid && m_ready`.
- **Read credit:** `rd_en` is allowed only when `occ + inflight - pop < 2`. `m_ready` therefore reaches `rd_en` combinationally.
- **FSM states:** IDLE, READ, DRAIN.
- **IDLE → READ** when any of the following holds; `burst_cnt` is cleared on entry:
  - `fifo_counter >= BURST_THRESH`
  - the idle timer equals `TIMEOUT` (nonzero) with `buf_empty=0`
- **IDLE → DRAIN** when `flush=1`. Flush has priority over the threshold and timeout triggers.
- **READ:**
  - issues reads whenever credit allows;
  - `burst_cnt` increments on each accepted read;
  - leaves for IDLE when `burst_cnt` reaches `BURST_LEN` or `buf_empty=1`;
  - moves to DRAIN if `flush` rises.
- **DRAIN:**
  - reads whenever credit allows, with no length limit;
  - returns to IDLE once `buf_empty=1`, `inflight=0` and `flush=0`;
  - while `flush` stays high, remains in DRAIN and serves new writes.
- **Idle timer:** 8-bit counter.
  - Increments in IDLE while `buf_empty=0`, saturating at `TIMEOUT`.
  - Clears when `buf_empty=1` or on leaving IDLE.
- **rd_count:** increments on each pop.
- **Reset:** mid-operation, reset discards the buffer contents and any in-flight word; a word already read from the FIFO is lost, by design.
- **Reset values:** `rd_en=0`, `m_valid=0`, `m_data=0`, `busy=0`, `rd_count=0`, state IDLE, `occ=0`, `inflight=0`, timer 0.

## Timing
- The trigger is sampled at edge N, putting the FSM in READ. The first `rd_en` is asserted in cycle N+1; the data lands in the buffer at edge N+2, so `m_valid` is high in cycle N+2.
- Sustained rate with `m_ready=1`: one word per cycle, i.e. a burst of `BURST_LEN` words completes in `BURST_LEN+2` cycles from the trigger.
- When `m_ready` drops:
  - at most one more read is accepted;
  - the buffer fills to 2;
  - `m_data` and `m_valid` hold stable until the pop.
- A pop and a buffer write in the same cycle keep `occ` unchanged, and ordering is preserved.
- `busy` is registered and follows the state and `occ` with one cycle of latency.

## Structure
- A shared package holds the FSM state enum (IDLE/READ/DRAIN) and default widths `DATA_W=8` and `CNT_W=7`.
- One sub-module, `skid_buf2`: the 2-entry register buffer with push, pop, occupancy, head-data and valid outputs.
- The top level holds the FSM, credit logic, timers and counters.

## Test plan
- **Reset check:** hold `rst=0` with `flush=1` and `m_ready=1` → all outputs 0 and no `rd_en` pulse; release reset → still no read while `fifo_counter<16`.
- **Threshold burst:** FIFO preloaded with 20 words (values 1..20), `m_ready=1` → exactly 16 reads; `m_data` shows 1..16 in consecutive cycles; return to IDLE; `rd_count=16`; 4 words remain in the FIFO.
- **Timeout:** preload 3 words, `TIMEOUT=8` → reading starts in the 9th idle cycle; 3 words delivered in order; FSM returns to IDLE on empty.
- **Backpressure:** burst of 16 with `m_ready` toggling 1,0,0,1 → no loss or duplication; `m_data` stable while `m_valid && !m_ready`; `rd_en` never asserted when `occ + inflight = 2`.
- **Flush:** pulse `flush` with 40 words stored → FIFO drained to empty; 40 words out in order; `rd_count=40`; FSM back in IDLE; `busy` low.
- **Reset mid-burst:** assert `rst` 5 words into a burst → `m_valid`, `rd_en` and `rd_count` go to 0 asynchronously; after release the threshold check restarts.
